// File: rtl/led_fader.sv
// PWM LED fader: each channel ramps its brightness towards the latched on/off target.
// Optional: define LED_FADER_GAMMA_EN for a squared (perceptual) PWM compare level.
module led_fader #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 65536,
  parameter int unsigned STEP     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pattern,
  input  logic             load,
  output logic [WIDTH-1:0] led,
  output logic             busy
);

  localparam int unsigned TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX_B  = '1;
  localparam logic [PWM_BITS:0]   MAX_W  = {1'b0, MAX_B};
  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);

  logic [WIDTH-1:0]    target;
  logic [PWM_BITS-1:0] bright     [WIDTH];
  logic [PWM_BITS-1:0] bright_nxt [WIDTH];
  logic [PWM_BITS-1:0] cmp_lvl    [WIDTH];
  logic [PWM_BITS:0]   sum        [WIDTH];
  logic [PWM_BITS:0]   diff       [WIDTH];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [WIDTH-1:0]    led_nxt;
  logic [WIDTH-1:0]    mismatch;

  assign tick = (tick_cnt == TW'(STEP_DIV - 1));

  // Stepping reads the registered target, so a load on a tick edge takes effect next tick.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]        = {1'b0, bright[i]} + STEP_W;
      diff[i]       = {1'b0, bright[i]} - STEP_W;
      bright_nxt[i] = bright[i];
      if (tick) begin
        if (target[i] && (bright[i] != MAX_B))
          bright_nxt[i] = (sum[i] > MAX_W) ? MAX_B : sum[i][PWM_BITS-1:0];
        else if (!target[i] && (bright[i] != '0))
          bright_nxt[i] = diff[i][PWM_BITS] ? '0 : diff[i][PWM_BITS-1:0];
      end
      mismatch[i] = target[i] ? (bright[i] != MAX_B) : (bright[i] != '0);
`ifdef LED_FADER_GAMMA_EN
      cmp_lvl[i] = PWM_BITS'(({{PWM_BITS{1'b0}}, bright[i]} * {{PWM_BITS{1'b0}}, bright[i]}) >> PWM_BITS);
`else
      cmp_lvl[i] = bright[i];
`endif
      led_nxt[i] = (bright[i] == MAX_B) || (pwm_cnt < cmp_lvl[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      target   <= '0;
      tick_cnt <= '0;
      pwm_cnt  <= '0;
      led      <= '0;
      busy     <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) bright[i] <= '0;
    end else begin
      if (load) target <= pattern;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      led      <= led_nxt;
      busy     <= |mismatch;
      for (int unsigned i = 0; i < WIDTH; i++) bright[i] <= bright_nxt[i];
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: fast-tick fades, retarget, tick/load collision, saturation, PWM duty.
module tb_led_fader;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [4:0] pattern;
  logic [4:0] led, led_s, led_d;
  logic       busy, busy_s, busy_d;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int cnt_on, cnt_other;

`ifdef LED_FADER_GAMMA_EN
  localparam int HALF_DUTY = 64;
`else
  localparam int HALF_DUTY = 128;
`endif

  always #5 clock = ~clock;

  led_fader #(.WIDTH(5), .PWM_BITS(8), .STEP_DIV(4), .STEP(64)) dut (
    .clock(clock), .reset(reset), .pattern(pattern), .load(load), .led(led), .busy(busy));

  led_fader #(.WIDTH(5), .PWM_BITS(8), .STEP_DIV(4), .STEP(100)) dut_sat (
    .clock(clock), .reset(reset), .pattern(pattern), .load(load), .led(led_s), .busy(busy_s));

  led_fader #(.WIDTH(5), .PWM_BITS(8), .STEP_DIV(512), .STEP(128)) dut_duty (
    .clock(clock), .reset(reset), .pattern(pattern), .load(load), .led(led_d), .busy(busy_d));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Edge n is the n-th rising edge after reset release; sampling happens on the following falling edge.
  task automatic run_to(input int e);
    while (edges < e) begin
      @(negedge clock);
      edges++;
    end
  endtask

  initial begin
    reset   = 1'b0;
    pattern = 5'b11111;
    load    = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_led", 32'(led), 0);
    check("rst_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++) check("rst_bright", 32'(dut.bright[i]), 0);
    check("rst_led_s", 32'(led_s), 0);
    check("rst_led_d", 32'(led_d), 0);
    load    = 1'b0;
    pattern = 5'b00000;
    reset   = 1'b1;

    run_to(8);
    check("idle_led", 32'(led), 0);
    check("idle_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++) check("idle_bright", 32'(dut.bright[i]), 0);

    // Fade up channel 0; ticks land on edges 12,16,20,24.
    pattern = 5'b00001; load = 1'b1;
    run_to(9);  load = 1'b0;
    check("up_busy_lat", 32'(busy), 0);
    run_to(10); check("up_busy", 32'(busy), 1);
    run_to(11); check("up_pre_tick", 32'(dut.bright[0]), 0);
    run_to(12); check("up_b64", 32'(dut.bright[0]), 64);
    check("sat_b100", 32'(dut_sat.bright[0]), 100);
    run_to(16); check("up_b128", 32'(dut.bright[0]), 128);
    check("sat_b200", 32'(dut_sat.bright[0]), 200);
    run_to(20); check("up_b192", 32'(dut.bright[0]), 192);
    check("sat_b255", 32'(dut_sat.bright[0]), 255);
    run_to(24); check("up_b255", 32'(dut.bright[0]), 255);
    check("up_busy_last", 32'(busy), 1);
    check("sat_hold", 32'(dut_sat.bright[0]), 255);
    check("sat_busy", 32'(busy_s), 0);
    check("up_b1", 32'(dut.bright[1]), 0);
    run_to(25); check("up_busy_drop", 32'(busy), 0);
    cnt_on = 0;
    for (int e = 26; e <= 40; e++) begin
      run_to(e);
      if (led == 5'b00001) cnt_on++;
    end
    check("full_on", 32'(cnt_on), 15);

    // Fade down from full.
    pattern = 5'b00000; load = 1'b1;
    run_to(41); load = 1'b0;
    run_to(44); check("dn_b191", 32'(dut.bright[0]), 191);
    check("sat_b155", 32'(dut_sat.bright[0]), 155);
    run_to(48); check("dn_b127", 32'(dut.bright[0]), 127);
    check("sat_b55", 32'(dut_sat.bright[0]), 55);
    run_to(52); check("dn_b63", 32'(dut.bright[0]), 63);
    check("sat_b0", 32'(dut_sat.bright[0]), 0);
    run_to(56); check("dn_b0", 32'(dut.bright[0]), 0);
    check("dn_busy", 32'(busy), 1);
    run_to(57); check("dn_busy_drop", 32'(busy), 0);
    check("dn_led", 32'(led), 0);

    // Retarget mid-fade at 128.
    run_to(60); pattern = 5'b00001; load = 1'b1;
    run_to(61); load = 1'b0;
    run_to(64); check("rt_b64", 32'(dut.bright[0]), 64);
    run_to(68); check("rt_b128", 32'(dut.bright[0]), 128);
    pattern = 5'b00000; load = 1'b1;
    run_to(69); load = 1'b0;
    run_to(72); check("rt_b64_dn", 32'(dut.bright[0]), 64);
    run_to(76); check("rt_b0", 32'(dut.bright[0]), 0);
    check("rt_busy", 32'(busy), 1);
    run_to(77); check("rt_busy_drop", 32'(busy), 0);

    // Load coincides with the tick at edge 88.
    run_to(80); pattern = 5'b00001; load = 1'b1;
    run_to(81); load = 1'b0;
    run_to(84); check("co_b64", 32'(dut.bright[0]), 64);
    run_to(87); pattern = 5'b00000; load = 1'b1;
    run_to(88); load = 1'b0;
    check("co_b128", 32'(dut.bright[0]), 128);
    run_to(92); check("co_b64_dn", 32'(dut.bright[0]), 64);
    run_to(96); check("co_b0", 32'(dut.bright[0]), 0);

    // Slow instance: parks at 128 from edge 512 and at 255 from edge 1024.
    run_to(100); pattern = 5'b00001; load = 1'b1;
    run_to(101); load = 1'b0;
    run_to(511); check("du_b0", 32'(dut_duty.bright[0]), 0);
    run_to(512); check("du_b128", 32'(dut_duty.bright[0]), 128);
    cnt_on = 0; cnt_other = 0;
    for (int e = 520; e <= 775; e++) begin
      run_to(e);
      if (led_d[0]) cnt_on++;
      if (led_d[4:1] != 4'b0000) cnt_other++;
    end
    check("duty_half", 32'(cnt_on), 32'(HALF_DUTY));
    check("duty_others", 32'(cnt_other), 0);
    run_to(1024); check("du_b255", 32'(dut_duty.bright[0]), 255);
    check("du_busy", 32'(busy_d), 1);
    run_to(1025); check("du_busy_drop", 32'(busy_d), 0);
    cnt_on = 0;
    for (int e = 1030; e <= 1285; e++) begin
      run_to(e);
      if (led_d[0]) cnt_on++;
    end
    check("duty_full", 32'(cnt_on), 256);
    check("main_led_on", 32'(led), 1);
    check("main_busy_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream of the pattern memory: consumes the 5-bit LED pattern and drives the physical LEDs.
- Each bit fades on or off with a PWM brightness ramp instead of switching hard.
- Runs on the fast board clock. A single-cycle `load` strobe, generated where the slow clock edge is detected, presents each new pattern.

Parameters:
- WIDTH, 5, number of LED channels.
- PWM_BITS, 8, brightness and PWM counter width; MAX = 2^PWM_BITS-1.
- STEP_DIV, 65536, clock cycles per brightness step (tick period); must be >= 2.
- STEP, 16, brightness change per tick; must be 1..MAX.

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- pattern, input, WIDTH, requested on/off state per LED.
- load, input, 1, single-cycle strobe that latches `pattern` as the new target.
- led, output, WIDTH, PWM drive per LED, registered.
- busy, output, 1, high while any channel's brightness differs from its target level.

Behaviour:
- Reset (reset=0, asynchronous): target, all bright[i], pwm_cnt, tick_cnt, led and busy go to 0. Reset mid-fade aborts the fade immediately; there is no recovery of the prior state.
- target register: on a clock edge with load=1, target <= pattern. A load while busy retargets; fading continues from the current brightness. A load equal to the current target has no effect.
- Target level per channel: MAX if target[i]=1, else 0.
- tick_cnt:
  - Free-running 0..STEP_DIV-1, wraps to 0.
  - tick is high in the cycle where tick_cnt = STEP_DIV-1.
- Step rule, per channel, on a tick edge only:
  - Up: if bright < level, bright <= min(bright+STEP, MAX).
  - Down: if bright > level, bright <= max(bright-STEP, 0).
  - Arithmetic is PWM_BITS+1 wide; there is never any wrap-around.
- Tick and load on the same edge: the step uses the old target. The new target governs from the next tick.
- pwm_cnt: free-running PWM_BITS counter, wraps MAX -> 0.
- led[i] <= (bright[i] = MAX) or (pwm_cnt < bright[i]).
  - One cycle of latency from bright/pwm_cnt to led.
  - bright=0 gives constant off; MAX gives constant on.
- busy <= OR over i of (bright[i] != level[i]), registered. It deasserts one cycle after the final step lands.
- Channel FSM (conceptual, per channel): IDLE (bright=level), RISING (bright<level), FALLING (bright>level).
  - Transitions are driven by a target change (load) or by reaching the level on a tick.
  - RISING<->FALLING is direct on retarget.
- Full fade time: ceil(MAX/STEP) ticks.

Optional Feature:
- Macro: LED_FADER_GAMMA_EN.
- Defined: the PWM compare uses a perceptual level g[i] = (bright[i]*bright[i]) >> PWM_BITS, i.e. led[i] <= (bright[i]=MAX) or (pwm_cnt < g[i]).
  - The multiply is combinational; led latency is unchanged at 1 cycle.
  - bright, busy and timing are identical to the non-gamma build.
- Undefined: the linear compare above; no multiplier is synthesized.

Test Plan:
All scenarios use WIDTH=5, PWM_BITS=8, STEP_DIV=4, STEP=64.
1. Reset:
   - Stimulus: hold reset=0 for 3 cycles with pattern=5'b11111, load=1.
   - Required: led=0, busy=0, bright=0. After release, all values stay 0 until the first load.
2. Fade up:
   - Stimulus: load with pattern=5'b00001.
   - Required: bright[0] steps 64,128,192,255 on 4 successive ticks (16 cycles); busy stays 1 until one cycle after it reaches 255.
   - Required: at bright=128, led[0] duty is 128/256 over one PWM period. At 255, led[0] is constantly 1. Other LEDs stay 0.
3. Retarget mid-fade:
   - Stimulus: with bright[0]=128 while rising, load pattern=5'b00000.
   - Required: next ticks give 64 then 0; busy drops after reaching 0.
4. Simultaneous tick and load:
   - Stimulus: assert load (pattern=0) in the same cycle as a tick while bright[0]=64 rising.
   - Required: bright[0] becomes 128 on that edge, then 64 on the next tick.
5. Saturation:
   - Stimulus: override STEP=100 and fade up.
   - Required: bright steps 100, 200, 255 with no overflow. Fading down gives 155, 55, 0 with no underflow.
6. Gamma build (LED_FADER_GAMMA_EN):
   - Stimulus: bright[0]=128.
   - Required: led[0] duty is 64/256. At bright=255, led[0] is constantly on. busy timing is identical to scenario 2.
